irq_controller: RTL and testbench

//   Prioritised interrupt controller sitting directly upstream of the mips core.

---
 rtl/irq_controller.sv | 132 +++++++++++++
 tb/tb_irq_controller.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/irq_controller.sv
// Prioritised interrupt controller: latches rising edges on src, presents the
// lowest-index unmasked pending source to the core as irq/EAddr, and tracks service.
module irq_controller #(
   parameter int unsigned N_SRC      = 8,
   parameter logic [31:0] VEC_STRIDE = 32'h0000_0020,
   parameter logic [31:0] VBASE_RST  = 32'h0000_0180
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_SRC-1:0] src,
   input  logic             we,
   input  logic [1:0]       addr,
   input  logic [31:0]      wd,
   output logic [31:0]      rd,
   input  logic             iack,
   output logic             irq,
   output logic [31:0]      EAddr,
   output logic             in_service
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      SERVICE = 2'd2
   } state_t;

   state_t             state, state_next;
   logic [N_SRC-1:0]   mask;
   logic [N_SRC-1:0]   pending;
   logic [N_SRC-1:0]   src_prev;
   logic [31:0]        vbase;
   logic [4:0]         id;
   logic [31:0]        eaddr_q;

   logic [N_SRC-1:0]   edge_det;
   logic [N_SRC-1:0]   active;
   logic [N_SRC-1:0]   clr;
   logic [4:0]         sel;
   logic               found;
   logic               load;
   logic               eoi;
   logic               take;

   assign edge_det = src & ~src_prev;
   assign active   = pending & mask;
   assign eoi      = we && (addr == 2'd3) && (state == SERVICE);
   assign take     = iack && (state == REQ);

   // Lowest set index wins; index 0 is the highest priority.
   always_comb begin
      found = 1'b0;
      sel   = '0;
      for (int unsigned i = 0; i < N_SRC; i++) begin
         if (active[i] && !found) begin
            found = 1'b1;
            sel   = 5'(i);
         end
      end
   end

   // Clears from iack and W1C are applied first so a same-cycle edge re-sets the bit.
   always_comb begin
      clr = '0;
      if (take)
         clr = clr | (N_SRC'(1) << id);
      if (we && (addr == 2'd1))
         clr = clr | wd[N_SRC-1:0];
   end

   always_comb begin
      state_next = state;
      load       = 1'b0;
      case (state)
         IDLE: begin
            if (found) begin
               load       = 1'b1;
               state_next = REQ;
            end
         end
         REQ: begin
            if (iack)
               state_next = SERVICE;
         end
         SERVICE: begin
            if (eoi)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         mask     <= '0;
         pending  <= '0;
         src_prev <= '0;
         vbase    <= VBASE_RST;
         id       <= '0;
         eaddr_q  <= VBASE_RST;
      end else begin
         state    <= state_next;
         src_prev <= src;
         pending  <= (pending & ~clr) | edge_det;
         if (we && (addr == 2'd0))
            mask <= wd[N_SRC-1:0];
         if (we && (addr == 2'd2))
            vbase <= {wd[31:2], 2'b00};
         // Vector is captured on entry to REQ so later VBASE writes cannot move it.
         if (load) begin
            id      <= sel;
            eaddr_q <= vbase + (32'(sel) * VEC_STRIDE);
         end
      end
   end

   assign irq        = (state == REQ);
   assign in_service = (state == SERVICE);
   assign EAddr      = eaddr_q;

   always_comb begin
      rd = '0;
      case (addr)
         2'd0: rd = 32'(mask);
         2'd1: rd = 32'(pending);
         2'd2: rd = vbase;
         2'd3: rd = {in_service, 26'b0, id};
         default: rd = '0;
      endcase
   end

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: hand-computed expectations for latency,
// priority, masking, W1C, set-over-clear, vector wrap and mid-service reset.
module tb_irq_controller;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  src;
   logic        we;
   logic [1:0]  addr;
   logic [31:0] wd;
   logic [31:0] rd;
   logic        iack;
   logic        irq;
   logic [31:0] EAddr;
   logic        in_service;

   int unsigned checks = 0;
   int unsigned errors = 0;

   irq_controller #(
      .N_SRC(8),
      .VEC_STRIDE(32'h0000_0020),
      .VBASE_RST(32'h0000_0180)
   ) dut (
      .clk(clk),
      .rst(rst),
      .src(src),
      .we(we),
      .addr(addr),
      .wd(wd),
      .rd(rd),
      .iack(iack),
      .irq(irq),
      .EAddr(EAddr),
      .in_service(in_service)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      addr = a;
      wd   = d;
      we   = 1'b1;
      tick();
      we   = 1'b0;
   endtask

   task automatic rdchk(input string tag, input logic [1:0] a, input logic [31:0] exp);
      addr = a;
      #1;
      check(tag, rd, exp);
   endtask

   task automatic pulse(input logic [7:0] s);
      src = s;
      tick();
      src = '0;
   endtask

   task automatic ack();
      iack = 1'b1;
      tick();
      iack = 1'b0;
   endtask

   initial begin
      rst = 1'b1; src = '0; we = 1'b0; addr = '0; wd = '0; iack = 1'b0;
      tick(); tick();
      rst = 1'b0;
      check("rst_irq", 32'(irq), 32'd0);
      check("rst_eaddr", EAddr, 32'h180);
      check("rst_insvc", 32'(in_service), 32'd0);
      rdchk("rst_mask", 2'd0, 32'h0);
      rdchk("rst_pend", 2'd1, 32'h0);
      rdchk("rst_vbase", 2'd2, 32'h180);

      // 1: single source, two-cycle latency
      wr(2'd0, 32'hFF);
      pulse(8'h08);
      check("t1_irq_early", 32'(irq), 32'd0);
      tick();
      check("t1_irq", 32'(irq), 32'd1);
      check("t1_eaddr", EAddr, 32'h1E0);
      ack();
      check("t1_irq_ack", 32'(irq), 32'd0);
      check("t1_insvc", 32'(in_service), 32'd1);
      rdchk("t1_pend", 2'd1, 32'h0);
      rdchk("t1_status", 2'd3, 32'h8000_0003);
      wr(2'd3, 32'h0);
      check("t1_eoi", 32'(in_service), 32'd0);

      // 2: simultaneous sources, priority then follow-on after EOI
      pulse(8'h24);
      tick();
      check("t2_irq", 32'(irq), 32'd1);
      check("t2_eaddr0", EAddr, 32'h1C0);
      ack();
      rdchk("t2_pend", 2'd1, 32'h20);
      wr(2'd3, 32'h0);
      check("t2_gap", 32'(irq), 32'd0);
      tick();
      check("t2_irq2", 32'(irq), 32'd1);
      check("t2_eaddr1", EAddr, 32'h220);
      ack();
      wr(2'd3, 32'h0);

      // 3: masked pending, late unmask, committed request survives W1C and mask
      wr(2'd0, 32'h00);
      pulse(8'h02);
      tick(); tick();
      check("t3_noirq", 32'(irq), 32'd0);
      rdchk("t3_pend", 2'd1, 32'h02);
      wr(2'd0, 32'h02);
      check("t3_irq_wait", 32'(irq), 32'd0);
      tick();
      check("t3_irq", 32'(irq), 32'd1);
      check("t3_eaddr", EAddr, 32'h1A0);
      wr(2'd1, 32'h02);
      check("t3_w1c_hold", 32'(irq), 32'd1);
      rdchk("t3_w1c_pend", 2'd1, 32'h0);
      wr(2'd0, 32'h00);
      check("t3_mask_hold", 32'(irq), 32'd1);
      check("t3_eaddr_hold", EAddr, 32'h1A0);
      ack();
      check("t3_insvc", 32'(in_service), 32'd1);
      wr(2'd3, 32'h0);

      // iack outside REQ has no effect on pending
      pulse(8'h08);
      ack();
      rdchk("iack_idle_pend", 2'd1, 32'h08);
      wr(2'd1, 32'h08);
      wr(2'd0, 32'hFF);

      // 4: no nesting; edge coincident with iack re-latches
      pulse(8'h40);
      tick();
      check("t4_eaddr6", EAddr, 32'h240);
      ack();
      pulse(8'h01);
      tick();
      check("t4_nonest", 32'(irq), 32'd0);
      check("t4_insvc", 32'(in_service), 32'd1);
      rdchk("t4_pend0", 2'd1, 32'h01);
      wr(2'd3, 32'h0);
      tick();
      check("t4_irq", 32'(irq), 32'd1);
      check("t4_eaddr0", EAddr, 32'h180);
      ack();
      wr(2'd3, 32'h0);
      pulse(8'h10);
      tick();
      check("t4_eaddr4", EAddr, 32'h200);
      src = 8'h10; iack = 1'b1;
      tick();
      src = '0; iack = 1'b0;
      rdchk("t4_setwins", 2'd1, 32'h10);
      wr(2'd3, 32'h0);
      tick();
      check("t4_rereq", 32'(irq), 32'd1);
      ack();
      wr(2'd3, 32'h0);

      // level-held source yields a single request
      src = 8'h80;
      tick(); tick();
      check("lvl_eaddr", EAddr, 32'h260);
      ack();
      rdchk("lvl_pend", 2'd1, 32'h0);
      wr(2'd3, 32'h0);
      tick();
      check("lvl_noreq", 32'(irq), 32'd0);
      src = '0;

      // 5: vector wrap, then reset mid-service
      wr(2'd2, 32'hFFFF_FFF3);
      rdchk("t5_vbase", 2'd2, 32'hFFFF_FFF0);
      pulse(8'h02);
      tick();
      check("t5_wrap", EAddr, 32'h0000_0010);
      ack();
      check("t5_insvc", 32'(in_service), 32'd1);
      rst = 1'b1; src = 8'h04;
      tick();
      rst = 1'b0;
      check("t5_rst_irq", 32'(irq), 32'd0);
      check("t5_rst_insvc", 32'(in_service), 32'd0);
      check("t5_rst_eaddr", EAddr, 32'h180);
      rdchk("t5_rst_mask", 2'd0, 32'h0);
      tick();
      rdchk("t5_held_pend", 2'd1, 32'h04);
      src = '0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
